// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry, tag SRAM word layout and FSM states for the icache tag controller
//
// Contents:
//   OFFSET_W / INDEX_W / TAG_W / ADDR_W : fetch address split (tag | index | offset)
//   tag_entry_t                         : one way slot {valid, tag}
//   tag_set_t                           : one SRAM word {way1, way0}
//   state_e                             : sequencing FSM states
//   fill_word()                         : SRAM write word carrying a tag in one way slot

package icache_pkg;

  localparam int OFFSET_W = 3;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 23;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef struct packed {
    tag_entry_t way1;
    tag_entry_t way0;
  } tag_set_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL_WR = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  // The slot that is not written is left at zero; the write mask keeps it untouched.
  function automatic tag_set_t fill_word(input logic way, input logic [TAG_W-1:0] tag);
    tag_set_t s;
    s = '0;
    if (way) begin
      s.way1.valid = 1'b1;
      s.way1.tag   = tag;
    end else begin
      s.way0.valid = 1'b1;
      s.way0.tag   = tag;
    end
    return s;
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// rtl/icache_victim_sel.sv - replacement way choice for a 2-way set
//
// Ports:
//   v0_i     : way0 valid bit of the set being filled
//   v1_i     : way1 valid bit of the set being filled
//   lru_i    : LRU bit of the set (names the way to evict)
//   victim_o : way to write (empty ways are used before evicting)

module icache_victim_sel
  import icache_pkg::*;
(
  input  logic v0_i,
  input  logic v1_i,
  input  logic lru_i,
  output logic victim_o
);

  always_comb begin
    if (!v0_i) begin
      victim_o = 1'b0;
    end else if (!v1_i) begin
      victim_o = 1'b1;
    end else begin
      victim_o = lru_i;
    end
  end

endmodule

// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - tag SRAM port arbiter, hit compare, LRU and victim selection for a 64-set 2-way icache
//
// Ports:
//   clk, rst_aL                          : clock, asynchronous active-low reset
//   lkp_valid/lkp_addr/lkp_ready         : fetch lookup request handshake
//   rsp_valid/rsp_hit/rsp_way            : lookup result, one cycle after acceptance
//   fill_valid/fill_addr/fill_ready      : miss fill request handshake
//   fill_done/fill_way                   : pulse when the fill tag is written, and the way used
//   flush_req/flush_busy                 : level invalidate-all request, sweep in progress
//   sram_csb/web/wmask/addr/din          : tag SRAM command, driven combinationally
//   sram_dout                            : tag SRAM read data, valid the cycle after a read

module icache_tag_ctrl #(
  parameter int ADDR_W   = icache_pkg::ADDR_W,
  parameter int OFFSET_W = icache_pkg::OFFSET_W,
  parameter int INDEX_W  = icache_pkg::INDEX_W,
  parameter int TAG_W    = icache_pkg::TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    lkp_valid,
  input  logic [ADDR_W-1:0]       lkp_addr,
  output logic                    lkp_ready,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic                    rsp_way,
  input  logic                    fill_valid,
  input  logic [ADDR_W-1:0]       fill_addr,
  output logic                    fill_ready,
  output logic                    fill_done,
  output logic                    fill_way,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [1:0]              sram_wmask,
  output logic [INDEX_W-1:0]      sram_addr,
  output logic [2*(TAG_W+1)-1:0]  sram_din,
  input  logic [2*(TAG_W+1)-1:0]  sram_dout
);
  import icache_pkg::*;

  state_e                  state_q;
  logic [INDEX_W-1:0]      lkp_idx_q;
  logic [TAG_W-1:0]        lkp_tag_q;
  logic [INDEX_W-1:0]      fill_idx_q;
  logic [TAG_W-1:0]        fill_tag_q;
  logic [INDEX_W-1:0]      flush_cnt_q;
  logic                    rsp_pend_q;
  logic [(1<<INDEX_W)-1:0] lru_q;

  tag_set_t rd_set;
  logic     hit0, hit1;
  logic     in_idle, in_fill_wr, in_flush;
  logic     fill_take, lkp_take;
  logic     victim;
  logic     unused_offset_bits;

  assign unused_offset_bits = ^{lkp_addr[OFFSET_W-1:0], fill_addr[OFFSET_W-1:0]};

  assign rd_set = tag_set_t'(sram_dout);

  // IDLE is qualified with reset so the handshakes and the SRAM command read
  // their reset values for as long as rst_aL is held, whatever the inputs do.
  assign in_idle    = rst_aL && (state_q == ST_IDLE);
  assign in_fill_wr = (state_q == ST_FILL_WR);
  assign in_flush   = (state_q == ST_FLUSH);

  // Priority in IDLE: flush, then fill, then lookup.
  assign fill_take  = in_idle && !flush_req && fill_valid;
  assign lkp_ready  = in_idle && !flush_req && !fill_valid;
  assign fill_ready = fill_take;
  assign lkp_take   = lkp_ready && lkp_valid;

  assign hit0 = rd_set.way0.valid && (rd_set.way0.tag == lkp_tag_q);
  assign hit1 = rd_set.way1.valid && (rd_set.way1.tag == lkp_tag_q);

  assign rsp_valid = rsp_pend_q;
  assign rsp_hit   = rsp_pend_q && (hit0 || hit1);
  assign rsp_way   = rsp_pend_q && hit1;

  // During FILL_WR sram_dout still holds the set read in the fill-accept cycle.
  icache_victim_sel u_victim_sel (
    .v0_i     (rd_set.way0.valid),
    .v1_i     (rd_set.way1.valid),
    .lru_i    (lru_q[fill_idx_q]),
    .victim_o (victim)
  );

  assign fill_done  = in_fill_wr;
  assign fill_way   = in_fill_wr && victim;
  assign flush_busy = in_flush;

  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = 2'b00;
    sram_addr  = '0;
    sram_din   = '0;
    if (fill_take) begin
      sram_csb  = 1'b0;
      sram_addr = fill_addr[OFFSET_W +: INDEX_W];
    end else if (lkp_take) begin
      sram_csb  = 1'b0;
      sram_addr = lkp_addr[OFFSET_W +: INDEX_W];
    end else if (in_fill_wr) begin
      sram_csb   = 1'b0;
      sram_web   = 1'b0;
      sram_wmask = victim ? 2'b10 : 2'b01;
      sram_addr  = fill_idx_q;
      sram_din   = fill_word(victim, fill_tag_q);
    end else if (in_flush) begin
      sram_csb   = 1'b0;
      sram_web   = 1'b0;
      sram_wmask = 2'b11;
      sram_addr  = flush_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q     <= ST_IDLE;
      lkp_idx_q   <= '0;
      lkp_tag_q   <= '0;
      fill_idx_q  <= '0;
      fill_tag_q  <= '0;
      flush_cnt_q <= '0;
      rsp_pend_q  <= 1'b0;
      lru_q       <= '0;
    end else begin
      rsp_pend_q <= lkp_take;
      if (lkp_take) begin
        lkp_idx_q <= lkp_addr[OFFSET_W +: INDEX_W];
        lkp_tag_q <= lkp_addr[ADDR_W-1 -: TAG_W];
      end
      // LRU names the way to evict next, so a hit points it at the other way.
      if (rsp_pend_q && (hit0 || hit1)) begin
        lru_q[lkp_idx_q] <= ~hit1;
      end
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
            // Placed after the hit update so the clear wins on the same edge.
            lru_q   <= '0;
          end else if (fill_valid) begin
            state_q    <= ST_FILL_WR;
            fill_idx_q <= fill_addr[OFFSET_W +: INDEX_W];
            fill_tag_q <= fill_addr[ADDR_W-1 -: TAG_W];
          end
        end
        ST_FILL_WR: begin
          lru_q[fill_idx_q] <= ~victim;
          state_q           <= ST_IDLE;
        end
        ST_FLUSH: begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
          if (flush_cnt_q == '1) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A set holding the same tag in both ways is a fill-side bug upstream.
  a_no_double_hit : assert property (@(posedge clk) disable iff (!rst_aL) rsp_pend_q |-> !(hit0 && hit1));

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - randomized self-checking bench for icache_tag_ctrl against a cache-level model

module tb_icache_tag_ctrl;

  localparam int TAG_W = 23;
  localparam int SETS  = 64;

  logic        clk;
  logic        rst_aL;
  logic        lkp_valid;
  logic [31:0] lkp_addr;
  logic        lkp_ready;
  logic        rsp_valid;
  logic        rsp_hit;
  logic        rsp_way;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic        fill_ready;
  logic        fill_done;
  logic        fill_way;
  logic        flush_req;
  logic        flush_busy;
  logic        sram_csb;
  logic        sram_web;
  logic [1:0]  sram_wmask;
  logic [5:0]  sram_addr;
  logic [47:0] sram_din;
  logic [47:0] sram_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  icache_tag_ctrl dut (
    .clk        (clk),
    .rst_aL     (rst_aL),
    .lkp_valid  (lkp_valid),
    .lkp_addr   (lkp_addr),
    .lkp_ready  (lkp_ready),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_way    (rsp_way),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_ready (fill_ready),
    .fill_done  (fill_done),
    .fill_way   (fill_way),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Tag SRAM macro: registered command, read data one cycle later, per-way write mask.
  logic [47:0] mem [SETS];
  always @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < SETS; i++) mem[i] <= '0;
      sram_dout <= '0;
    end else if (!sram_csb) begin
      if (sram_web) begin
        sram_dout <= mem[sram_addr];
      end else begin
        if (sram_wmask[0]) mem[sram_addr][23:0]  <= sram_din[23:0];
        if (sram_wmask[1]) mem[sram_addr][47:24] <= sram_din[47:24];
      end
    end
  end

  // Cache-level reference: per set, two slots {valid, tag} and the way to evict next.
  bit             mv   [SETS][2];
  logic [TAG_W-1:0] mt [SETS][2];
  bit             mlru [SETS];

  function automatic int a_idx(input logic [31:0] a);
    return int'((a >> 3) % 32'd64);
  endfunction

  function automatic logic [TAG_W-1:0] a_tag(input logic [31:0] a);
    logic [31:0] t;
    t = a >> 9;
    return t[TAG_W-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) begin
      mv[i][0] = 1'b0;
      mv[i][1] = 1'b0;
      mlru[i]  = 1'b0;
    end
  endtask

  function automatic bit model_present(input logic [31:0] a);
    bit found;
    found = 1'b0;
    for (int w = 0; w < 2; w++)
      if (mv[a_idx(a)][w] && mt[a_idx(a)][w] == a_tag(a)) found = 1'b1;
    return found;
  endfunction

  task automatic model_lookup(input logic [31:0] a, output bit h, output bit way);
    h   = 1'b0;
    way = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (mv[a_idx(a)][w] && mt[a_idx(a)][w] == a_tag(a)) begin
        h   = 1'b1;
        way = w[0];
      end
    end
    if (h) mlru[a_idx(a)] = !way;
  endtask

  function automatic bit model_victim(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (!mv[a_idx(a)][w]) return w[0];
    return mlru[a_idx(a)];
  endfunction

  task automatic model_fill(input logic [31:0] a, input bit way);
    mv[a_idx(a)][way] = 1'b1;
    mt[a_idx(a)][way] = a_tag(a);
    mlru[a_idx(a)]    = !way;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at a drive point (just after a rising edge).
  task automatic do_lookup(input logic [31:0] a, output bit h_obs, output bit w_obs);
    bit eh, ew;
    int n;
    lkp_valid = 1'b1;
    lkp_addr  = a;
    n = 0;
    @(negedge clk);
    while (!lkp_ready && n < 20) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    check_eq("lkp_ready", lkp_ready, 1);
    model_lookup(a, eh, ew);
    next_cycle();
    lkp_valid = 1'b0;
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_hit", rsp_hit, eh);
    check_eq("rsp_way", rsp_way, ew);
    h_obs = rsp_hit;
    w_obs = rsp_way;
    next_cycle();
  endtask

  task automatic do_fill(input logic [31:0] a, output bit w_obs);
    bit ev;
    logic [47:0] exp_din;
    fill_valid = 1'b1;
    fill_addr  = a;
    @(negedge clk);
    check_eq("fill_ready", fill_ready, 1);
    check_eq("fill_lkp_blocked", lkp_ready, 0);
    next_cycle();
    fill_valid = 1'b0;
    @(negedge clk);
    ev = model_victim(a);
    exp_din = ev ? {1'b1, a_tag(a), 24'h0} : {24'h0, 1'b1, a_tag(a)};
    check_eq("fill_done", fill_done, 1);
    check_eq("fill_way", fill_way, ev);
    check_eq("fill_wmask", {sram_csb, sram_web, sram_wmask}, {2'b00, ev ? 2'b10 : 2'b01});
    check_eq("fill_sram_addr", sram_addr, a_idx(a));
    check_eq("fill_din", sram_din, exp_din);
    model_fill(a, ev);
    w_obs = fill_way;
    next_cycle();
  endtask

  // Starts at a drive point; returns at the falling edge of the first IDLE cycle
  // after the sweep with the other request inputs untouched.
  task automatic do_flush();
    int n, bad;
    flush_req = 1'b1;
    @(negedge clk);
    check_eq("flush_grant_blocks", {lkp_ready, fill_ready, sram_csb}, 3'b001);
    model_clear();
    next_cycle();
    flush_req = 1'b0;
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (flush_busy && n < 80) begin
      if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_wmask !== 2'b11 ||
          sram_addr !== n[5:0] || sram_din !== 48'h0 || lkp_ready !== 1'b0 || fill_ready !== 1'b0)
        bad++;
      n++;
      next_cycle();
      @(negedge clk);
    end
    check_eq("flush_cycles", n, 64);
    check_eq("flush_writes_bad", bad, 0);
  endtask

  bit          h, w;
  bit          eh [4];
  bit          ew [4];
  logic [31:0] A  [4];
  logic [31:0] B  [4];
  logic [31:0] F;
  int          sets [4] = '{0, 1, 2, 63};
  bit          ready_exp [6] = '{1, 1, 0, 0, 1, 1};

  initial begin
    rst_aL     = 1'b0;
    lkp_valid  = 1'b0;
    lkp_addr   = '0;
    fill_valid = 1'b0;
    fill_addr  = '0;
    flush_req  = 1'b0;
    model_clear();

    // Reset values
    @(negedge clk);
    check_eq("rst_handshakes", {lkp_ready, fill_ready, rsp_valid, fill_done, flush_busy}, 5'b0);
    check_eq("rst_sram_ctl", {sram_csb, sram_web, sram_wmask}, 4'b1100);
    check_eq("rst_sram_addr_din", {sram_addr, sram_din}, 54'h0);
    next_cycle();
    rst_aL = 1'b1;
    @(negedge clk);
    check_eq("idle_lkp_ready", lkp_ready, 1);
    next_cycle();

    // Flush, then a lookup misses
    do_flush();
    next_cycle();
    do_lookup(32'h0000_1238, h, w);
    check_eq("post_flush_miss", h, 0);

    // Fill/lookup/LRU sequence on set 8
    do_fill(32'h8000_0040, w);
    check_eq("fill_a_way0", w, 0);
    do_lookup(32'h8000_0044, h, w);
    check_eq("lkp_a_hit", {h, w}, 2'b10);
    do_fill(32'h9000_0040, w);
    check_eq("fill_b_way1", w, 1);
    do_lookup(32'h8000_0040, h, w);
    check_eq("lkp_a_hit_again", {h, w}, 2'b10);
    check_eq("lru8_after_way0_hit", dut.lru_q[8], 1);
    do_fill(32'hA000_0040, w);
    check_eq("fill_c_evicts_way1", w, 1);
    do_lookup(32'h8000_0040, h, w);
    check_eq("lkp_a_survives", {h, w}, 2'b10);
    do_lookup(32'h9000_0040, h, w);
    check_eq("lkp_b_evicted", h, 0);

    // flush, fill and lookup together: flush, then fill, then lookup
    fill_valid = 1'b1;
    fill_addr  = 32'h8000_0040;
    lkp_valid  = 1'b1;
    lkp_addr   = 32'h8000_0040;
    do_flush();
    check_eq("after_flush_fill_first", {fill_ready, lkp_ready}, 2'b10);
    next_cycle();
    fill_valid = 1'b0;
    @(negedge clk);
    check_eq("contend_fill_done", fill_done, 1);
    check_eq("contend_lkp_held", lkp_ready, 0);
    model_fill(32'h8000_0040, model_victim(32'h8000_0040));
    next_cycle();
    @(negedge clk);
    check_eq("contend_lkp_after_fill", lkp_ready, 1);
    model_lookup(32'h8000_0040, eh[0], ew[0]);
    next_cycle();
    lkp_valid = 1'b0;
    @(negedge clk);
    check_eq("contend_rsp", {rsp_valid, rsp_hit, rsp_way}, {1'b1, eh[0], ew[0]});
    check_eq("contend_rsp_hit", rsp_hit, 1);
    next_cycle();

    // Back-to-back lookups to four sets
    for (int i = 0; i < 4; i++) A[i] = (32'd3 << 9) | (32'(10 + i) << 3);
    do_fill(A[0], w);
    do_fill(A[2], w);
    for (int c = 0; c < 5; c++) begin
      lkp_valid = (c < 4);
      lkp_addr  = A[c % 4];
      @(negedge clk);
      if (c < 4) begin
        check_eq("b2b_ready", lkp_ready, 1);
        model_lookup(A[c], eh[c], ew[c]);
      end
      if (c > 0) check_eq("b2b_rsp", {rsp_valid, rsp_hit, rsp_way}, {1'b1, eh[c-1], ew[c-1]});
      next_cycle();
    end
    @(negedge clk);
    check_eq("b2b_rsp_end", rsp_valid, 0);
    next_cycle();

    // Fill request in cycle 2 of a lookup stream stalls lkp_ready for two cycles
    F    = 32'h0100_00A0;
    B[0] = 32'h0000_02A8;
    B[1] = 32'h0000_02B0;
    B[2] = F;
    B[3] = 32'h0000_04A0;
    begin
      int  li;
      bit  acc, acc_prev, peh, pew, ev;
      li = 0;
      acc_prev = 1'b0;
      peh = 1'b0;
      pew = 1'b0;
      for (int c = 0; c < 7; c++) begin
        lkp_valid  = (li < 4);
        lkp_addr   = B[li % 4];
        fill_valid = (c == 2);
        fill_addr  = F;
        @(negedge clk);
        if (acc_prev) check_eq("stall_rsp", {rsp_valid, rsp_hit, rsp_way}, {1'b1, peh, pew});
        else          check_eq("stall_no_rsp", rsp_valid, 0);
        if (c < 6) check_eq("stall_ready", lkp_ready, ready_exp[c]);
        if (c == 2) check_eq("stall_fill_ready", fill_ready, 1);
        if (c == 3) begin
          ev = model_victim(F);
          check_eq("stall_fill_done", {fill_done, fill_way}, {1'b1, ev});
          model_fill(F, ev);
        end
        acc = lkp_valid && lkp_ready;
        if (acc) begin
          model_lookup(B[li], peh, pew);
          li++;
        end
        acc_prev = acc;
        next_cycle();
      end
      lkp_valid  = 1'b0;
      fill_valid = 1'b0;
      check_eq("stall_all_accepted", li, 4);
    end

    // Randomized mix against the model
    for (int n = 0; n < 300; n++) begin
      int r, si, tg, tries;
      logic [31:0] a;
      r  = $urandom_range(99, 0);
      si = sets[$urandom_range(3, 0)];
      tg = $urandom_range(5, 0);
      a  = (32'(tg) << 9) | (32'(si) << 3) | 32'($urandom_range(7, 0));
      if (r < 3) begin
        do_flush();
        next_cycle();
      end else if (r < 38) begin
        tries = 0;
        while (model_present(a) && tries < 20) begin
          tg = $urandom_range(5, 0);
          a  = (32'(tg) << 9) | (32'(si) << 3);
          tries++;
        end
        if (!model_present(a)) do_fill(a, w);
      end else begin
        do_lookup(a, h, w);
      end
    end

    // Reset in the middle of a flush sweep
    begin
      int n;
      flush_req = 1'b1;
      next_cycle();
      flush_req = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(flush_busy && sram_addr == 6'd20) && n < 40) begin
        next_cycle();
        @(negedge clk);
        n++;
      end
      check_eq("mid_flush_cnt20", {flush_busy, sram_addr}, {1'b1, 6'd20});
      rst_aL = 1'b0;
      #1;
      check_eq("midrst_busy", flush_busy, 0);
      check_eq("midrst_sram", {sram_csb, sram_web, sram_wmask, sram_addr}, {4'b1100, 6'd0});
      check_eq("midrst_din", sram_din, 0);
      check_eq("midrst_handshakes", {lkp_ready, fill_ready, rsp_valid, fill_done}, 4'b0);
      check_eq("midrst_lru", dut.lru_q, 64'h0);
      model_clear();
      @(posedge clk);
      #1;
      rst_aL = 1'b1;
      @(negedge clk);
      check_eq("midrst_idle", {lkp_ready, flush_busy}, 2'b10);
      next_cycle();
      do_fill(32'h8000_0040, w);
      check_eq("midrst_fill_way0", w, 0);
      do_lookup(32'h8000_0040, h, w);
      check_eq("midrst_lkp_hit", {h, w}, 2'b10);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
- Sequencing/arbitration controller for the 64-set, 2-way icache tag SRAM (48-bit word; way1 = [47] valid, [46:24] tag; way0 = [23] valid, [22:0] tag; 2-bit write mask, one bit per way).
- Shares the single RW port between three requesters: fetch lookups, miss fills and flush (invalidate-all).
- Owns the per-set LRU state, hit compare and victim selection.
- Sits between the fetch stage / miss handler and the tag SRAM macro.

Parameters:
- ADDR_W, 32, fetch address width
- OFFSET_W, 3, line offset bits
- INDEX_W, 6, set index bits (64 sets)
- TAG_W, 23, tag bits; ADDR_W = TAG_W + INDEX_W + OFFSET_W

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous reset, active low
- lkp_valid  in  1  lookup request
- lkp_addr  in  ADDR_W  lookup address
- lkp_ready  out  1  lookup accepted this cycle when valid&ready
- rsp_valid  out  1  lookup result valid
- rsp_hit  out  1  tag hit
- rsp_way  out  1  hit way (0 when miss)
- fill_valid  in  1  fill request
- fill_addr  in  ADDR_W  fill address
- fill_ready  out  1  fill accepted
- fill_done  out  1  one-cycle pulse, tag written
- fill_way  out  1  way written, valid with fill_done
- flush_req  in  1  level request; invalidate all sets
- flush_busy  out  1  flush sweep in progress
- sram_csb  out  1  chip select, active low
- sram_web  out  1  write enable, active low
- sram_wmask  out  2  per-way write mask
- sram_addr  out  INDEX_W  set index
- sram_din  out  2*(TAG_W+1)  write data
- sram_dout  in  2*(TAG_W+1)  read data, valid the cycle after the read is driven

Behaviour:
- Reset (async, rst_aL=0): state IDLE, lru[63:0]=0, flush counter 0, all response/handshake outputs 0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
- SRAM port signals are driven combinationally in cycle N. The macro registers them at posedge. Read data is sampled combinationally in cycle N+1.
- States: IDLE, FILL_WR, FLUSH.
- IDLE priority: flush_req > fill_valid > lkp_valid.
  - flush_req=1: go to FLUSH. No SRAM access this cycle. lkp_ready=fill_ready=0.
  - Else fill_valid=1: fill_ready=1. Drive read of fill set. Capture index/tag. Go to FILL_WR. lkp_ready=0.
  - Else: lkp_ready=1. On lkp_valid, drive read of lookup set and register tag/index. Stay IDLE. Back-to-back lookups every cycle.
- Lookup response, cycle N+1 after acceptance:
  - rsp_valid=1.
  - hitw = dout.way_v && dout.way_tag==reg_tag.
  - rsp_hit = hit0|hit1; rsp_way = hit1.
  - On hit, lru[idx] <= ~rsp_way at posedge (lru names the victim way).
  - Both ways hitting is illegal; assertion, way1 is reported.
- FILL_WR (1 cycle):
  - Victim = way0 if !v0; else way1 if !v1; else lru[idx].
  - Drive write: din = {1,tag} in the victim slot, zeros elsewhere; wmask one-hot on the victim.
  - fill_done=1, fill_way=victim, lru[idx] <= ~victim. Return to IDLE.
  - lkp_ready=fill_ready=0.
  - flush_req arriving during FILL_WR waits until the fill completes.
- FLUSH:
  - flush_busy=1. Write din=0, wmask=2'b11 to addr=cnt; cnt increments 0..63.
  - Clear the whole lru array on entry.
  - After the write of set 63: cnt wraps to 0 and the FSM returns to IDLE. 64 cycles total.
  - No handshakes accepted while flushing.
  - flush_req is not re-sampled until IDLE. If it is still high on return to IDLE, a second flush runs.
- Hazards:
  - A lookup accepted in the cycle after a FILL_WR to the same set observes the new tag; no bypass is required.
  - The response to a lookup accepted in the cycle before a fill appears during the fill-read cycle (allowed).
- Reset mid-fill or mid-flush: sweep aborts and state returns to IDLE. SRAM contents are the macro's concern (the macro also clears on rst_aL).

Decomposition:
- Package icache_pkg:
  - OFFSET_W, INDEX_W, TAG_W constants.
  - Packed typedef tag_entry_t {valid, tag}.
  - Typedef tag_set_t {way1, way0} (48 bits).
  - FSM state enum.
- One sub-module, icache_victim_sel: combinational valid/LRU victim choice. Everything else stays inline.

Test Plan:
- Reset, then flush: 64 writes, addr 0..63, wmask=11, din=0. flush_busy high exactly 64 cycles. Next lookup to 0x0000_1238 -> rsp_hit=0 one cycle later.
- Fill 0x8000_0040 (idx 8, tag 0x400000) -> fill_way=0. Lookup 0x8000_0044 -> rsp_hit=1, rsp_way=0, response 1 cycle after acceptance.
- Fill 0x9000_0040 (same set) -> way1. Lookup hitting way0 sets lru[8]=1. Third fill 0xA000_0040 -> fill_way=1, and way0 still hits.
- flush_req, fill_valid and lkp_valid asserted together in IDLE -> flush wins; fill accepted on the first IDLE cycle after 64 flush cycles; lookup accepted only after fill_done.
- Back-to-back lookups to 4 different sets over 4 cycles -> 4 consecutive rsp_valid cycles. A fill request in cycle 2 stalls lkp_ready for 2 cycles.
- rst_aL pulsed low during FLUSH at cnt=20 -> outputs return to reset values immediately; flush_busy=0; lru all 0.
